// File: rtl/vp12_seq_pkg.sv
// Shared types and constants for the VP12 regulator power sequencer.
// Register offsets locate the control fields in the PTC register map.
package vp12_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

  localparam int DEF_STAGGER_CYCLES = 125000;
  localparam int DEF_ALERT_FILTER   = 1000;

  localparam int REG_CH_REQ_LSB    = 0;
  localparam int REG_FAULT_CLR_LSB = 16;
  localparam int REG_KILL_CLR_BIT  = 32;

endpackage

// File: rtl/vp12_alert_filter.sv
// Per-channel alert conditioning: 2-FF synchroniser on the open-drain alert,
// saturating low-time counter and a trip strobe while the channel is enabled.
module vp12_alert_filter
  import vp12_seq_pkg::*;
#(
  parameter int ALERT_FILTER = DEF_ALERT_FILTER
) (
  input  logic clk_axi,
  input  logic rst,
  input  logic i_alert_n,
  input  logic i_ch_en,
  output logic o_trip
);

  localparam int             CW      = $clog2(ALERT_FILTER + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(ALERT_FILTER);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_alert_n};
      // Alerts from a regulator that is off are meaningless, so the count restarts.
      if (!i_ch_en || r_sync[1]) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_trip = i_ch_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/vp12_power_sequencer.sv
// Staggered turn-on of N_CH regulators, lowest index first, with per-channel
// alert trips and a latched global kill that drops every rail.
module vp12_power_sequencer
  import vp12_seq_pkg::*;
#(
  parameter int N_CH           = 6,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int ALERT_FILTER   = DEF_ALERT_FILTER
) (
  input  logic            clk_axi,
  input  logic            rst,
  input  logic [N_CH-1:0] ch_req,
  input  logic [N_CH-1:0] fault_clr,
  input  logic [N_CH-1:0] alert_n,
  input  logic            global_kill,
  input  logic            kill_clr,
  output logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] fault,
  output logic            kill_latched,
  output logic            busy
);

  localparam int            TW         = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(STAGGER_CYCLES - 1);
  // With a one-cycle stagger there is nothing to wait for between turn-ons.
  localparam seq_state_t    ON_STATE   = (STAGGER_CYCLES > 1) ? WAIT : IDLE;

  seq_state_t      r_state, w_state_next;
  logic [TW-1:0]   r_timer, w_timer_next;
  logic [N_CH-1:0] r_ch_en, w_ch_en_next;
  logic [N_CH-1:0] r_fault;
  logic            r_kill_latched;
  logic [1:0]      r_kill_sync;
  logic            w_kill;
  logic            w_turn_on;
  logic [N_CH-1:0] w_trip;
  logic [N_CH-1:0] w_elig;
  logic [N_CH-1:0] w_pick;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_filt
      vp12_alert_filter #(
        .ALERT_FILTER(ALERT_FILTER)
      ) u_filt (
        .clk_axi  (clk_axi),
        .rst      (rst),
        .i_alert_n(alert_n[gi]),
        .i_ch_en  (r_ch_en[gi]),
        .o_trip   (w_trip[gi])
      );
    end
  endgenerate

  assign w_kill = r_kill_sync[1];
  assign w_elig = ch_req & ~r_ch_en & ~r_fault & {N_CH{~r_kill_latched}};
  // Two's-complement trick isolates the lowest set eligible bit.
  assign w_pick = w_elig & (~w_elig + N_CH'(1));

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_turn_on    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_turn_on    = 1'b1;
          w_timer_next = TIMER_LOAD;
          w_state_next = ON_STATE;
        end
      end
      WAIT: begin
        if (r_timer <= TW'(1)) begin
          w_timer_next = '0;
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_kill) begin
      w_turn_on    = 1'b0;
      w_timer_next = '0;
      w_state_next = IDLE;
    end
  end

  always_comb begin
    w_ch_en_next = '0;
    if (!w_kill) begin
      w_ch_en_next = (r_ch_en & ch_req & ~w_trip) | (w_turn_on ? w_pick : '0);
    end
  end

  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_ch_en        <= '0;
      r_fault        <= '0;
      r_kill_latched <= 1'b0;
      r_kill_sync    <= 2'b00;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_ch_en        <= w_ch_en_next;
      // A trip on the same edge as a clear wins.
      r_fault        <= (r_fault & ~fault_clr) | w_trip;
      r_kill_latched <= w_kill | (r_kill_latched & ~kill_clr);
      r_kill_sync    <= {r_kill_sync[0], global_kill};
    end
  end

  assign ch_en        = r_ch_en;
  assign fault        = r_fault;
  assign kill_latched = r_kill_latched;
  assign busy         = ~rst & ((r_state == WAIT) | (|w_elig));

endmodule

// File: doc/vp12_power_sequencer.md
Name: vp12_power_sequencer

Overview:
- Parametrised successor to the fixed per-rail VP12 enable bits in the PTC top level.
- Takes per-channel enable requests from the R/W register file and turns regulators on one at a time, lowest index first, with a programmable stagger.
- Monitors each channel's open-drain LTC alert and trips the channel on a sustained alert, latching a fault.
- A global kill input (over-temperature OR'd externally) drops all rails and latches.

Parameters:
- N_CH, 6, number of regulator channels (1..16)
- STAGGER_CYCLES, 125000, clk_axi cycles between consecutive channel turn-ons (>=1)
- ALERT_FILTER, 1000, consecutive low alert samples required to trip a channel (>=1)

Ports:
- clk_axi  in  1  system/AXI clock; only clock
- rst  in  1  synchronous, active-high reset
- ch_req  in  N_CH  per-channel enable request (register bits, level)
- fault_clr  in  N_CH  per-channel fault clear, 1-cycle pulse
- alert_n  in  N_CH  asynchronous, active-low regulator alert
- global_kill  in  1  asynchronous, active-high kill
- kill_clr  in  1  kill latch clear, 1-cycle pulse
- ch_en  out  N_CH  registered regulator enable to pins
- fault  out  N_CH  latched per-channel trip
- kill_latched  out  1  latched global kill
- busy  out  1  sequencer has pending turn-ons or a running stagger timer

Behaviour:
- Reset: ch_en=0, fault=0, kill_latched=0, busy=0, stagger timer=0, state=IDLE, filter counters=0, synchronisers preset to 1 (alert_n) / 0 (kill).
- alert_n and global_kill pass through 2-FF synchronisers before use.
- A channel is eligible when ch_req=1, ch_en=0, fault=0 and kill_latched=0.
- FSM IDLE:
  - If any channel is eligible, set ch_en of the lowest-index eligible channel on the next edge; load the timer with STAGGER_CYCLES-1; go to WAIT.
  - Latency from ch_req rising to ch_en rising is 1 cycle.
- FSM WAIT:
  - Timer decrements each cycle.
  - At 0, go to IDLE. The next turn-on is therefore exactly STAGGER_CYCLES cycles after the previous one.
  - If STAGGER_CYCLES=1, turn-ons occur on consecutive cycles.
- Turn-off on ch_req=0: ch_en clears on the next edge, independent of FSM state, with no stagger.
  - If ch_req falls in the same cycle the channel is selected, it is not enabled.
- busy = (state==WAIT) OR (any channel eligible).
- Alert filter, per channel:
  - The counter increments while ch_en=1 and the synced alert is low.
  - It clears when the synced alert is high or ch_en=0.
  - Alerts are ignored while the channel is off.
  - When the counter reaches ALERT_FILTER, fault is set and ch_en is cleared on the same edge. If alert_n is first sampled low at edge k, ch_en falls at edge k+ALERT_FILTER+2.
  - The counter saturates; it does not wrap. Width is clog2(ALERT_FILTER+1).
- fault_clr clears fault on the next edge.
  - A trip in the same cycle takes priority over the clear.
  - After a clear, a still-requested channel becomes eligible and re-sequences normally.
- Global kill:
  - A synced global_kill=1 sets kill_latched; ch_en for all channels goes 0 on the next edge; FSM goes to IDLE; the timer is cleared.
  - kill_clr is honoured only when the synced global_kill=0; otherwise it is ignored.
  - After a kill clear, requested channels re-sequence from the lowest index.
  - fault bits are unaffected by kill.
- Reset asserted mid-sequence returns everything to reset values on the next edge. No partial state survives.

Decomposition:
- Shared package vp12_seq_pkg:
  - FSM state enum {IDLE, WAIT}.
  - Default constants DEF_STAGGER_CYCLES and DEF_ALERT_FILTER.
  - Register bit offsets for ch_req, fault_clr and kill_clr in the PTC register map.
- Sub-module vp12_alert_filter: 2-FF synchroniser, saturating debounce counter and trip strobe. Instantiated N_CH times via generate. The top holds the FSM, timer, priority pick and latches.

Test Plan (N_CH=6, STAGGER_CYCLES=8, ALERT_FILTER=4):
- Reset, then ch_req=6'b111111 at cycle 0 -> ch_en bits 0..5 rise at cycles 1, 9, 17, 25, 33, 41; busy falls at cycle 48.
- ch_req=6'b000101, then ch_req[0] dropped at cycle 5 -> ch_en[0] falls at cycle 6; ch_en[2] rises at cycle 9.
- Channel 3 enabled, alert_n[3] low from edge k -> ch_en[3]=0 and fault[3]=1 at edge k+6. A 3-cycle low glitch on alert_n[3] produces no trip.
- fault_clr[3] pulsed while alert_n[3] is still low and the counter is at the trip edge -> fault[3] stays 1. Later clear with alert high -> ch_en[3] re-enabled 1 cycle after the clear.
- global_kill pulse during WAIT -> all ch_en=0 within 3 cycles and kill_latched=1. kill_clr while kill is still high -> ignored. kill_clr after kill releases -> re-sequence from ch 0 with 8-cycle spacing.
- rst asserted during WAIT with 3 channels on -> all outputs 0 on the next edge; after rst release, re-sequence starts from ch 0.
